vedic_mac_sched: RTL and testbench

Sequencer that time-shares one 4x4 Vedic multiplier (`gabung_coba`) across TAPS sample/coefficient pairs to compute one adaptive-filter tap dot product. Latches a full operand set on `start`, walks the taps through a registered multiply/accumulate loop, and presents the sum with a valid/ready handshake. Sits between the filter's tap-delay line and weight-update logic and the shared multiplier resource.

---
 rtl/vedic_mac_sched_pkg.sv | 29 ++
 rtl/vedic_mac_sched_mul.sv | 28 ++
 rtl/vedic_mac_sched.sv | 99 +++++++++
 tb/tb_vedic_mac_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vedic_mac_sched_pkg.sv
// Shared definitions for the time-shared Vedic MAC sequencer: FSM state
// encodings, operand width and the 2x2 Vedic multiply building block.
package vedic_mac_sched_pkg;

  localparam int OPW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Urdhva-Tiryagbhyam 2x2 product built from AND gates and two half adders.
  function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
    logic t1, t2, t3, c1;
    logic [3:0] p;
    t1   = a[1] & b[0];
    t2   = a[0] & b[1];
    t3   = a[1] & b[1];
    c1   = t1 & t2;
    p[0] = a[0] & b[0];
    p[1] = t1 ^ t2;
    p[2] = t3 ^ c1;
    p[3] = t3 & c1;
    return p;
  endfunction

endpackage

// File: rtl/vedic_mac_sched_mul.sv
// gabung_coba: combinational 4x4 unsigned Vedic multiplier assembled from
// four 2x2 Vedic blocks; o_cout is the carry past bit 7 (always 0 for 4x4).
module gabung_coba
  import vedic_mac_sched_pkg::*;
(
  input  logic [OPW-1:0]   i_a,
  input  logic [OPW-1:0]   i_b,
  output logic [2*OPW-1:0] o_p,
  output logic             o_cout
);

  logic [3:0] w_ll, w_lh, w_hl, w_hh;
  logic [5:0] w_mid;
  logic [8:0] w_sum;

  assign w_ll = vedic2x2(i_a[1:0], i_b[1:0]);
  assign w_lh = vedic2x2(i_a[1:0], i_b[3:2]);
  assign w_hl = vedic2x2(i_a[3:2], i_b[1:0]);
  assign w_hh = vedic2x2(i_a[3:2], i_b[3:2]);

  // Cross terms share weight 4, the high term weight 16.
  assign w_mid = {2'b00, w_lh} + {2'b00, w_hl};
  assign w_sum = {5'b0, w_ll} + {1'b0, w_mid, 2'b00} + {1'b0, w_hh, 4'b0000};

  assign o_p    = w_sum[7:0];
  assign o_cout = w_sum[8];

endmodule

// File: rtl/vedic_mac_sched.sv
// Sequencer that time-shares one gabung_coba multiplier across TAPS
// sample/coefficient pairs and returns the dot product over valid/ready.
module vedic_mac_sched
  import vedic_mac_sched_pkg::*;
#(
  parameter int TAPS  = 4,
  parameter int ACC_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OPW*TAPS-1:0]   x_vec,
  input  logic [OPW*TAPS-1:0]   w_vec,
  output logic                  busy,
  output logic [ACC_W-1:0]      y,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic                  ovf
);

  localparam int IDX_W = $clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t                r_state, w_nextState;
  logic [OPW*TAPS-1:0]   r_xOps, r_wOps;
  logic [IDX_W-1:0]      r_idx;
  logic [2*OPW-1:0]      r_prodQ;
  logic [ACC_W-1:0]      r_acc;
  logic                  r_ovf;
  logic [OPW-1:0]        w_xSel, w_wSel;
  logic [2*OPW-1:0]      w_prod;
  logic                  w_coutUnused;
  logic [ACC_W:0]        w_accSum;

  assign w_xSel = r_xOps[r_idx*OPW +: OPW];
  assign w_wSel = r_wOps[r_idx*OPW +: OPW];

  gabung_coba u_mul (
    .i_a    (w_xSel),
    .i_b    (w_wSel),
    .o_p    (w_prod),
    .o_cout (w_coutUnused)
  );

  assign w_accSum = {1'b0, r_acc} + {{(ACC_W + 1 - 2*OPW){1'b0}}, r_prodQ};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_MUL;
      S_MUL:   w_nextState = S_ACC;
      S_ACC:   w_nextState = (r_idx == LAST_IDX) ? S_DONE : S_MUL;
      S_DONE:  if (y_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Operands are captured only on an accepted start so mid-run input churn is invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xOps  <= '0;
      r_wOps  <= '0;
      r_idx   <= '0;
      r_prodQ <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_xOps <= x_vec;
            r_wOps <= w_vec;
            r_idx  <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
          end
        end
        S_MUL: r_prodQ <= w_prod;
        S_ACC: begin
          r_acc <= w_accSum[ACC_W-1:0];
          r_ovf <= r_ovf | w_accSum[ACC_W];
          if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign y_valid = (r_state == S_DONE);
  assign y       = r_acc;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_vedic_mac_sched.sv
// Directed and random checks of vedic_mac_sched with TAPS=4 at ACC_W=10 and
// ACC_W=9, both instances driven by the same stimulus.
module tb_vedic_mac_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] xVec, wVec;
  logic        yReady;
  logic        busy, yValid, ovf;
  logic [9:0]  y;
  logic        busy9, yValid9, ovf9;
  logic [8:0]  y9;

  int nChecks = 0;
  int nFails = 0;
  int coutErrs = 0;
  int cycles;
  int validSeen;
  logic busyDropped;
  int ry10, rovf10, ry9, rovf9;
  logic [15:0] rx, rw;

  vedic_mac_sched #(.TAPS(4), .ACC_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .x_vec(xVec), .w_vec(wVec),
    .busy(busy), .y(y), .y_valid(yValid), .y_ready(yReady), .ovf(ovf)
  );

  vedic_mac_sched #(.TAPS(4), .ACC_W(9)) dut9 (
    .clk(clk), .rst(rst), .start(start), .x_vec(xVec), .w_vec(wVec),
    .busy(busy9), .y(y9), .y_valid(yValid9), .y_ready(yReady), .ovf(ovf9)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.u_mul.o_cout !== 1'b0 || dut9.u_mul.o_cout !== 1'b0) coutErrs++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the sampling edge.
  task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] wv);
    xVec  = xv;
    wVec  = wv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitForValid();
    cycles = 1;
    busyDropped = !busy;
    while (!yValid && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (!busy) busyDropped = 1'b1;
    end
    checkOutput("valid timeout", yValid, 1);
  endtask

  task automatic runCheck(input string tag, input logic [15:0] xv, input logic [15:0] wv,
                          input int eY, input int eOvf, input int eY9, input int eOvf9);
    applyStimulus(xv, wv);
    waitForValid();
    checkOutput({tag, " latency"}, cycles, 9);
    checkOutput({tag, " busy"}, busyDropped, 0);
    checkOutput({tag, " y"}, y, eY);
    checkOutput({tag, " ovf"}, ovf, eOvf);
    checkOutput({tag, " y9"}, y9, eY9);
    checkOutput({tag, " ovf9"}, ovf9, eOvf9);
    @(negedge clk);
  endtask

  function automatic void refModel(input logic [15:0] xv, input logic [15:0] wv,
                                   output int y10, output int o10, output int y9m, output int o9);
    int p;
    y10 = 0; o10 = 0; y9m = 0; o9 = 0;
    for (int i = 0; i < 4; i++) begin
      p = int'(xv[4*i +: 4]) * int'(wv[4*i +: 4]);
      y10 += p;
      if (y10 >= 1024) begin y10 -= 1024; o10 = 1; end
      y9m += p;
      if (y9m >= 512) begin y9m -= 512; o9 = 1; end
    end
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; xVec = '0; wVec = '0; yReady = 1'b1;
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset y", y, 0);
    checkOutput("reset y_valid", yValid, 0);
    checkOutput("reset ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle busy", busy, 0);

    runCheck("dot1234", 16'h1234, 16'h5678, 70, 0, 70, 0);
    runCheck("allF", 16'hFFFF, 16'hFFFF, 900, 0, 388, 1);

    // Backpressure with operand/start churn during the run and in DONE.
    yReady = 1'b0;
    applyStimulus(16'h2222, 16'h3333);
    cycles = 1;
    while (!yValid && cycles < 40) begin
      xVec = 16'($urandom); wVec = 16'($urandom); start = ~start;
      @(negedge clk);
      cycles++;
    end
    checkOutput("bp latency", cycles, 9);
    checkOutput("bp y", y, 24);
    checkOutput("bp ovf", ovf, 0);
    for (int k = 0; k < 5; k++) begin
      xVec = 16'($urandom); wVec = 16'($urandom); start = k[0];
      @(negedge clk);
      checkOutput("bp hold y", y, 24);
      checkOutput("bp hold valid", yValid, 1);
    end
    start = 1'b0;
    yReady = 1'b1;
    @(negedge clk);
    checkOutput("bp valid drop", yValid, 0);
    checkOutput("bp idle", busy, 0);

    // Back-to-back with start held high.
    xVec = 16'h3333; wVec = 16'h4444; start = 1'b1;
    @(negedge clk);
    xVec = 16'h1234; wVec = 16'h1111;
    cycles = 1;
    while (!yValid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("b2b first latency", cycles, 9);
    checkOutput("b2b first y", y, 48);
    @(negedge clk);
    checkOutput("b2b gap idle", busy, 0);
    @(negedge clk);
    checkOutput("b2b restart", busy, 1);
    start = 1'b0; xVec = 16'hFFFF; wVec = 16'hFFFF;
    waitForValid();
    checkOutput("b2b second latency", cycles, 9);
    checkOutput("b2b second y", y, 10);
    @(negedge clk);

    // Async reset during ACC of tap 2.
    applyStimulus(16'h5555, 16'h5555);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("pre-reset acc", y, 50);
    checkOutput("pre-reset busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort y_valid", yValid, 0);
    checkOutput("abort y", y, 0);
    checkOutput("abort ovf", ovf, 0);
    checkOutput("abort y9", y9, 0);
    @(negedge clk);
    rst = 1'b0;
    validSeen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (yValid || busy) validSeen++;
    end
    checkOutput("abort no result", validSeen, 0);
    runCheck("post-reset", 16'h1111, 16'h2222, 8, 0, 8, 0);

    for (int n = 0; n < 1000; n++) begin
      rx = 16'($urandom);
      rw = 16'($urandom);
      refModel(rx, rw, ry10, rovf10, ry9, rovf9);
      runCheck("random", rx, rw, ry10, rovf10, ry9, rovf9);
    end

    checkOutput("mul cout", coutErrs, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
